// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_pkg
//  Description : Shared constants and parameter legality check for the
//                multiplexed seven-segment scan driver.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_scan_driver_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF    = 7'h7F;  // all segments dark (active-low bus)
    localparam logic [3:0] AN_OFF     = 4'hF;   // all anodes off (active-low)

    // Legal configuration: a slot needs at least one blank clock and at
    // least one lit clock; the blink half-period is at least one frame.
    function automatic bit params_legal(input int scan_div,
                                        input int blank_cyc,
                                        input int blink_div);
        return (scan_div >= 2) && (blank_cyc >= 1) &&
               (blank_cyc < scan_div) && (blink_div >= 1);
    endfunction

endpackage : seg_scan_driver_pkg
`default_nettype wire

// File: rtl/seg_scan_driver_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-N up counter with count enable, synchronous clear
//                and a combinational wrap pulse (high while enabled at N-1).
//  Ports       : clk, reset_n (async, active-low), en, clr,
//                count [W-1:0], wrap
//  Revision    : 1.0  initial release
// ============================================================================
module mod_counter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] r_count;

    assign wrap  = en && (r_count == W'(N - 1));
    assign count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + W'(1);
        end
    end

endmodule : mod_counter
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for a four-digit common-anode
//                seven-segment display. Digit patterns are snapshotted once
//                per frame; each digit slot starts with a blank interval to
//                suppress ghosting. Optional per-digit blinking.
//  Ports       : clk, reset_n (async, active-low), enable,
//                digit0..digit3 [6:0] (active-high), blinkMask [3:0],
//                seg [6:0] (active-low), an [3:0] (active-low),
//                frameStart (pulse after each snapshot)
//  Build macro : SEG_SCAN_BLINK_EN - include blink mask / frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [6:0] digit0,
    input  logic [6:0] digit1,
    input  logic [6:0] digit2,
    input  logic [6:0] digit3,
    input  logic [3:0] blinkMask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frameStart
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    generate
        if (!params_legal(SCAN_DIV, BLANK_CYC, BLINK_DIV)) begin : g_param_check
            $fatal(1, "seg_scan_driver: illegal SCAN_DIV/BLANK_CYC/BLINK_DIV");
        end
    endgenerate

    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_wrap;
    logic [IDX_W-1:0] r_idx;
    logic [6:0]       r_shadow [NUM_DIGITS];
    logic             w_snap;
    logic             w_blank_digit;
    logic [6:0]       w_seg_nxt;
    logic [3:0]       w_an_nxt;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_frame_start;

    // Slot counter; dropping enable parks it at zero so the first enabled
    // edge afterwards is a snapshot edge.
    mod_counter #(.N(SCAN_DIV), .W(CNT_W)) u_slot_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (enable),
        .clr     (!enable),
        .count   (w_cnt),
        .wrap    (w_cnt_wrap)
    );

    assign w_snap = enable && (r_idx == '0) && (w_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (!enable) begin
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_snap) begin
            r_shadow[0] <= digit0;
            r_shadow[1] <= digit1;
            r_shadow[2] <= digit2;
            r_shadow[3] <= digit3;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic [3:0]  r_mask_shadow;
    logic        r_blink_phase;
    logic        w_frame_wrap;
    logic [((BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1)-1:0] w_frame_cnt_unused;

    // Counts snapshots; wraps once per blink half-period.
    mod_counter #(.N(BLINK_DIV)) u_frame_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_snap),
        .clr     (1'b0),
        .count   (w_frame_cnt_unused),
        .wrap    (w_frame_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask_shadow <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_snap) begin
                r_mask_shadow <= blinkMask;
            end
            if (w_frame_wrap) begin
                r_blink_phase <= !r_blink_phase;
            end
        end
    end

    assign w_blank_digit = r_blink_phase && r_mask_shadow[r_idx];
`else
    logic w_blink_mask_unused;
    assign w_blink_mask_unused = ^blinkMask;
    assign w_blank_digit       = 1'b0;
`endif

    // Next output values from the pre-edge position and current shadow.
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        if (enable && (w_cnt >= CNT_W'(BLANK_CYC))) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_blank_digit ? SEG_OFF : ~r_shadow[r_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg         <= SEG_OFF;
            r_an          <= AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt;
            r_an          <= w_an_nxt;
            r_frame_start <= w_snap;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frameStart = r_frame_start;

endmodule : seg_scan_driver
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (SCAN_DIV=4,
//                BLANK_CYC=1, BLINK_DIV=2). A frame-position model predicts
//                seg/an/frameStart every cycle; directed literals pin it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int BD    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       enable    = 1'b0;
    logic [6:0] digit0    = 7'h00;
    logic [6:0] digit1    = 7'h00;
    logic [6:0] digit2    = 7'h00;
    logic [6:0] digit3    = 7'h00;
    logic [3:0] blinkMask = 4'h0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frameStart;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .blinkMask  (blinkMask),
        .seg        (seg),
        .an         (an),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: position within the frame ----------
    int         m_pos   = 0;   // enabled edges since last snapshot edge, mod FRAME
    int         m_snaps = 0;   // snapshots since reset
    logic [6:0] m_shadow [4];
    logic [3:0] m_mask  = 4'h0;
    logic [6:0] exp_seg = 7'h7F;
    logic [3:0] exp_an  = 4'hF;
    logic       exp_fs  = 1'b0;

    function automatic logic blink_off(input int snaps, input logic [3:0] mask, input int d);
`ifdef SEG_SCAN_BLINK_EN
        return (((snaps / BD) % 2) == 1) && mask[d];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos   <= 0;
            m_snaps <= 0;
            m_mask  <= 4'h0;
            for (int i = 0; i < 4; i++) m_shadow[i] <= 7'h00;
            exp_seg <= 7'h7F;
            exp_an  <= 4'hF;
            exp_fs  <= 1'b0;
        end else if (!enable) begin
            m_pos   <= 0;
            exp_seg <= 7'h7F;
            exp_an  <= 4'hF;
            exp_fs  <= 1'b0;
        end else begin
            exp_fs <= (m_pos == 0);
            if (m_pos == 0) begin
                m_snaps     <= m_snaps + 1;
                m_shadow[0] <= digit0;
                m_shadow[1] <= digit1;
                m_shadow[2] <= digit2;
                m_shadow[3] <= digit3;
                m_mask      <= blinkMask;
            end
            if ((m_pos % SD) >= BC) begin
                exp_an  <= ~(4'b0001 << (m_pos / SD));
                exp_seg <= blink_off(m_snaps, m_mask, m_pos / SD) ? 7'h7F
                                                                   : ~m_shadow[m_pos / SD];
            end else begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h7F;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_frameStart", 32'(frameStart), 32'(exp_fs));
            chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    task automatic wait_an(input logic [3:0] val);
        int n = 0;
        while (an !== val && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wait_an_timeout", 32'(an), 32'(val));
    endtask

    logic [3:0] an_tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_fs", 32'(frameStart), 32'h0);
        reset_n = 1'b1;

        // Basic scan + snapshot behaviour
        digit3 = 7'h06; digit2 = 7'h5B; digit1 = 7'h4F; digit0 = 7'h66;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);               // sampled after E_k
            chk("scan_an", 32'(an), 32'(an_tbl[k % 16]));
            chk("scan_fs", 32'(frameStart), 32'((k % 16) == 0));
            if (an == 4'hE)
                chk("scan_seg_d0", 32'(seg), (k < 16) ? 32'h19 : 32'h40);
            if (an == 4'h7)
                chk("scan_seg_d3", 32'(seg), 32'h79);
            if (k == 5) digit0 = 7'h3F;
        end

        // Reset mid-scan while digit 2 is lit
        wait_an(4'hB);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_seg", 32'(seg), 32'h7F);
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_fs", 32'(frameStart), 32'h0);
`ifdef SEG_SCAN_BLINK_EN
        blinkMask = 4'b0001;
`else
        blinkMask = 4'hF;
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Five frames after restart: digit 0 blink pattern, digit 1 steady
        for (int f = 1; f <= 5; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                @(negedge clk);
                if (p == 0) chk("restart_fs", 32'(frameStart), 32'h1);
                if (p == 1) begin
                    chk("blink_an_d0", 32'(an), 32'hE);
`ifdef SEG_SCAN_BLINK_EN
                    chk("blink_seg_d0", 32'(seg), (f == 2 || f == 3) ? 32'h7F : 32'h40);
`else
                    chk("blink_seg_d0", 32'(seg), 32'h40);
`endif
                end
                if (p == 5) chk("blink_seg_d1", 32'(seg), 32'h30);
            end
        end

        // Enable drop while digit 2 is lit
        wait_an(4'hB);
        enable = 1'b0;
        @(negedge clk);
        chk("endrop_an", 32'(an), 32'hF);
        chk("endrop_seg", 32'(seg), 32'h7F);
        chk("endrop_fs", 32'(frameStart), 32'h0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("enrise_fs", 32'(frameStart), 32'h1);
        chk("enrise_an", 32'(an), 32'hF);
        @(negedge clk);
        chk("enrise_an_d0", 32'(an), 32'hE);
        repeat (FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_driver
`default_nettype wire
